// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared types and default vectors for the fetch PC generator
package mips_pc_pkg;

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} pc_state_e;

   // Winning next-PC source; HOLD covers stall, halt and boot cycles.
   typedef enum logic [2:0] {
      SRC_HOLD, SRC_SEQ, SRC_EXC, SRC_ERET, SRC_BR, SRC_JMP, SRC_RAS
   } pc_src_e;

   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

   function automatic logic is_redirect(pc_src_e s);
      return (s == SRC_EXC) || (s == SRC_ERET) || (s == SRC_BR) ||
             (s == SRC_JMP) || (s == SRC_RAS);
   endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address LIFO that overwrites the oldest entry when full
module ras_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_top;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_top_inc;
   logic             w_pop;

   assign w_top_inc = r_top + PW'(1);
   assign w_pop     = pop && (r_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_top   <= '0;
         r_count <= '0;
      end else if (push && w_pop) begin
         r_top <= r_top;
      end else if (push) begin
         r_top <= w_top_inc;
         if (r_count != CW'(DEPTH))
            r_count <= r_count + CW'(1);
      end else if (w_pop) begin
         r_top   <= r_top - PW'(1);
         r_count <= r_count - CW'(1);
      end
   end

   // Push with a simultaneous pop replaces the current top in place.
   always_ff @(posedge clk) begin
      if (push)
         r_mem[w_pop ? r_top : w_top_inc] <= push_data;
   end

   assign top   = r_mem[r_top];
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with prioritised redirects, halt and RAS
module pc_gen
   import mips_pc_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
   parameter int               STEP      = 4,
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             halt,
   input  logic             resume,
   input  logic             exc_req,
   input  logic             eret,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp_valid,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             ras_push,
   input  logic [WIDTH-1:0] ras_push_addr,
   input  logic             ras_pop,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic [WIDTH-1:0] epc,
   output logic             flush,
   output logic             ras_empty
);

   localparam int CW = $clog2(RAS_DEPTH + 1);

   pc_state_e        r_state, w_state_next;
   pc_src_e          w_src;
   logic [WIDTH-1:0] r_pc, r_epc, w_pc_next, w_epc_next, w_ras_top;
   logic             r_flush, r_pc_valid;
   logic             w_ras_push, w_ras_pop, w_ras_empty;
   logic [CW-1:0]    w_ras_count;

   ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (w_ras_push),
      .pop       (w_ras_pop),
      .push_data (ras_push_addr),
      .top       (w_ras_top),
      .empty     (w_ras_empty),
      .count     (w_ras_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_BOOT;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_src        = SRC_HOLD;
      w_state_next = r_state;
      case (r_state)
         ST_BOOT: w_state_next = ST_RUN;
         ST_RUN: begin
            if (exc_req)                              w_src = SRC_EXC;
            else if (eret)                            w_src = SRC_ERET;
            else if (br_taken)                        w_src = SRC_BR;
            else if (jmp_valid)                       w_src = SRC_JMP;
            else if (ras_pop && (w_ras_count != '0))  w_src = SRC_RAS;
            else if (halt || stall)                   w_src = SRC_HOLD;
            else                                      w_src = SRC_SEQ;
            if (halt && !is_redirect(w_src))
               w_state_next = ST_HALT;
         end
         ST_HALT: begin
            if (exc_req)
               w_src = SRC_EXC;
            if (exc_req || resume)
               w_state_next = ST_RUN;
         end
         default: w_state_next = ST_BOOT;
      endcase
   end

   always_comb begin
      w_pc_next = r_pc;
      case (w_src)
         SRC_EXC:  w_pc_next = EXC_VEC;
         SRC_ERET: w_pc_next = r_epc;
         SRC_BR:   w_pc_next = br_target;
         SRC_JMP:  w_pc_next = jmp_target;
         SRC_RAS:  w_pc_next = w_ras_top;
         SRC_SEQ:  w_pc_next = r_pc + WIDTH'(STEP);
         default:  w_pc_next = r_pc;
      endcase
      w_epc_next = (w_src == SRC_EXC) ? r_pc : r_epc;
      w_ras_push = (r_state == ST_RUN) && ras_push && !exc_req;
      w_ras_pop  = (w_src == SRC_RAS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_VEC;
         r_epc      <= '0;
         r_flush    <= 1'b0;
         r_pc_valid <= 1'b0;
      end else begin
         r_pc       <= w_pc_next;
         r_epc      <= w_epc_next;
         r_flush    <= is_redirect(w_src);
         r_pc_valid <= (w_state_next == ST_RUN);
      end
   end

   assign pc        = r_pc;
   assign epc       = r_epc;
   assign flush     = r_flush;
   assign pc_valid  = r_pc_valid;
   assign ras_empty = w_ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed and randomized checks of pc_gen against a queue-based model
module tb_pc_gen;

   localparam logic [31:0] EXC = 32'h8000_0180;
   localparam int          DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        stall, halt, resume, exc_req, eret, br_taken, jmp_valid, ras_push, ras_pop;
   logic [31:0] br_target, jmp_target, ras_push_addr;
   logic [31:0] pc, epc;
   logic        pc_valid, flush, ras_empty;

   logic        z1 = 1'b0;
   logic [7:0]  z8 = 8'h00;
   logic        j8_valid;
   logic [7:0]  j8_target;
   logic [7:0]  pc8, epc8;
   logic        valid8, flush8, empty8;

   pc_gen u_dut (
      .clk(clk), .rst(rst), .stall(stall), .halt(halt), .resume(resume),
      .exc_req(exc_req), .eret(eret), .br_taken(br_taken), .br_target(br_target),
      .jmp_valid(jmp_valid), .jmp_target(jmp_target), .ras_push(ras_push),
      .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .pc(pc), .pc_valid(pc_valid),
      .epc(epc), .flush(flush), .ras_empty(ras_empty)
   );

   pc_gen #(.WIDTH(8), .STEP(4)) u_dut8 (
      .clk(clk), .rst(rst), .stall(z1), .halt(z1), .resume(z1),
      .exc_req(z1), .eret(z1), .br_taken(z1), .br_target(z8),
      .jmp_valid(j8_valid), .jmp_target(j8_target), .ras_push(z1),
      .ras_push_addr(z8), .ras_pop(z1), .pc(pc8), .pc_valid(valid8),
      .epc(epc8), .flush(flush8), .ras_empty(empty8)
   );

   int total = 0;
   int bad   = 0;

   bit          m_run, m_halt;
   logic [31:0] m_pc, m_epc;
   logic        m_flush, m_valid;
   logic [31:0] m_ras[$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".pc"},        pc,                 m_pc);
      chk({tag, ".pc_valid"},  32'(pc_valid),      32'(m_valid));
      chk({tag, ".epc"},       epc,                m_epc);
      chk({tag, ".flush"},     32'(flush),         32'(m_flush));
      chk({tag, ".ras_empty"}, 32'(ras_empty),     32'(m_ras.size() == 0));
   endtask

   task automatic clr_in();
      stall = 0; halt = 0; resume = 0; exc_req = 0; eret = 0; br_taken = 0;
      jmp_valid = 0; ras_push = 0; ras_pop = 0;
      br_target = 0; jmp_target = 0; ras_push_addr = 0;
   endtask

   task automatic model_reset();
      m_run = 0; m_halt = 0; m_pc = 0; m_epc = 0; m_flush = 0; m_valid = 0;
      m_ras.delete();
   endtask

   task automatic model_edge();
      logic        redirect, won_pop;
      logic [31:0] npc;
      redirect = 0; won_pop = 0; npc = m_pc;
      if (!m_run && !m_halt) begin
         m_run = 1;
      end else if (m_halt) begin
         if (exc_req) begin
            m_epc = m_pc; npc = EXC; redirect = 1; m_halt = 0; m_run = 1;
         end else if (resume) begin
            m_halt = 0; m_run = 1;
         end
      end else begin
         if (exc_req) begin
            m_epc = m_pc; npc = EXC; redirect = 1;
         end else if (eret) begin
            npc = m_epc; redirect = 1;
         end else if (br_taken) begin
            npc = br_target; redirect = 1;
         end else if (jmp_valid) begin
            npc = jmp_target; redirect = 1;
         end else if (ras_pop && m_ras.size() > 0) begin
            npc = m_ras[0]; redirect = 1; won_pop = 1;
         end else if (halt) begin
            m_run = 0; m_halt = 1;
         end else if (!stall) begin
            npc = m_pc + 32'd4;
         end
         if (ras_push && !exc_req) begin
            if (won_pop) m_ras[0] = ras_push_addr;
            else begin
               m_ras.push_front(ras_push_addr);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_back());
            end
         end else if (won_pop) begin
            void'(m_ras.pop_front());
         end
      end
      m_pc = npc; m_flush = redirect; m_valid = m_run;
   endtask

   task automatic tick(string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      clr_in();
      j8_valid = 0; j8_target = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 0;
      check_all("release");
      tick("boot");
      chk("boot.valid_const", 32'(pc_valid), 32'd1);
      tick("seq1"); chk("seq1.const", pc, 32'd4);
      tick("seq2"); chk("seq2.const", pc, 32'd8);
      tick("seq3"); chk("seq3.const", pc, 32'd12);

      jmp_valid = 1; jmp_target = 32'h10; tick("jmp10"); clr_in();
      stall = 1; br_taken = 1; br_target = 32'h200; tick("br_over_stall");
      chk("br_over_stall.const", pc, 32'h200);
      br_taken = 0; tick("stall_only");
      chk("stall_only.flush", 32'(flush), 32'd0);
      clr_in();

      jmp_valid = 1; jmp_target = 32'h44; tick("jmp44"); clr_in();
      exc_req = 1; br_taken = 1; br_target = 32'h300; tick("exc_over_br");
      chk("exc.epc_const", epc, 32'h44);
      clr_in(); tick("exc_seq");
      eret = 1; tick("eret"); clr_in();
      chk("eret.const", pc, 32'h44);

      for (int i = 0; i < 5; i++) begin
         ras_push = 1; ras_push_addr = 32'h100 + 32'(4 * i); tick("ras_push");
      end
      clr_in();
      for (int i = 0; i < 5; i++) begin
         ras_pop = 1; tick("ras_pop");
         if (i < 4) chk("ras_pop.const", pc, 32'h110 - 32'(4 * i));
         if (i == 3) chk("ras_pop.empty", 32'(ras_empty), 32'd1);
         if (i == 4) chk("ras_pop.fallthru_flush", 32'(flush), 32'd0);
      end
      clr_in();

      jmp_valid = 1; jmp_target = 32'h20; tick("jmp20"); clr_in();
      halt = 1; tick("halt");
      chk("halt.valid_const", 32'(pc_valid), 32'd0);
      halt = 0; br_taken = 1; br_target = 32'h400; ras_push = 1; ras_push_addr = 32'h55;
      tick("halt_ignore");
      chk("halt_ignore.pc_const", pc, 32'h20);
      clr_in(); exc_req = 1; tick("halt_exc");
      chk("halt_exc.pc_const", pc, EXC);
      chk("halt_exc.valid_const", 32'(pc_valid), 32'd1);
      clr_in();
      halt = 1; tick("halt2"); clr_in();
      resume = 1; tick("resume"); clr_in();
      tick("resume_seq");

      ras_push = 1; ras_push_addr = 32'hA0; tick("pp_a");
      ras_push_addr = 32'hB0; tick("pp_b"); clr_in();
      ras_pop = 1; ras_push = 1; ras_push_addr = 32'hC0; tick("push_pop");
      chk("push_pop.const", pc, 32'hB0);
      clr_in(); ras_pop = 1; tick("pop_c"); tick("pop_a"); clr_in();

      jmp_valid = 1; jmp_target = 32'hFFFF_FFFC; tick("jmp_top"); clr_in();
      tick("wrap32"); chk("wrap32.const", pc, 32'd0);

      j8_valid = 1; j8_target = 8'hFC; tick("w8_jmp");
      chk("w8.pc_fc", 32'(pc8), 32'hFC);
      chk("w8.flush1", 32'(flush8), 32'd1);
      j8_valid = 0; tick("w8_wrap");
      chk("w8.pc_wrap", 32'(pc8), 32'h00);
      chk("w8.flush0", 32'(flush8), 32'd0);
      chk("w8.valid", 32'(valid8), 32'd1);
      chk("w8.epc", 32'(epc8), 32'd0);
      chk("w8.empty", 32'(empty8), 32'd1);

      ras_push = 1; ras_push_addr = 32'h77; tick("pre_areset"); clr_in();
      exc_req = 1; tick("pre_areset_exc"); clr_in();
      rst = 1; #1; model_reset(); check_all("areset");
      @(posedge clk); #1; rst = 0;
      tick("areset_boot");

      repeat (400) begin
         exc_req       = ($urandom % 16) == 0;
         eret          = ($urandom % 12) == 0;
         br_taken      = ($urandom % 8) == 0;
         jmp_valid     = ($urandom % 8) == 0;
         ras_push      = ($urandom % 4) == 0;
         ras_pop       = ($urandom % 4) == 0;
         stall         = ($urandom % 4) == 0;
         halt          = ($urandom % 10) == 0;
         resume        = ($urandom % 3) == 0;
         br_target     = $urandom & 32'hFFFF_FFFC;
         jmp_target    = $urandom & 32'hFFFF_FFFC;
         ras_push_addr = $urandom & 32'hFFFF_FFFC;
         if (($urandom % 97) == 0) begin
            clr_in();
            rst = 1; #1; model_reset(); check_all("rnd_areset");
            @(posedge clk); #1; rst = 0;
         end else begin
            tick("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS fetch stage. It holds the fetch PC and advances it by a fixed step each cycle, with stall and halt. It takes prioritised redirects from exceptions, exception return, branches, jumps and a return-address stack (RAS). It drives the instruction-memory address, a fetch-valid flag and a one-cycle pipeline flush to the decode stage.

## Interface
- WIDTH, 32, PC/address width in bits
- RESET_VEC, 0, PC value loaded by reset
- EXC_VEC, 'h80000180, exception handler entry address
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, asynchronous and active-high
- stall  in  1  hold PC (sequential advance only)
- halt  in  1  request halt of fetch
- resume  in  1  leave halt
- exc_req  in  1  exception taken
- eret  in  1  return from exception
- br_taken  in  1  branch resolved taken
- br_target  in  WIDTH  branch target
- jmp_valid  in  1  jump/jal
- jmp_target  in  WIDTH  jump target
- ras_push  in  1  push return address (jal)
- ras_push_addr  in  WIDTH  address to push
- ras_pop  in  1  jr $ra: redirect to RAS top
- pc  out  WIDTH  current fetch address
- pc_valid  out  1  pc is a valid fetch this cycle
- epc  out  WIDTH  saved exception PC
- flush  out  1  discard the instruction fetched in the previous cycle
- ras_empty  out  1  RAS holds no entries

## Operation
- States: BOOT, RUN, HALT.
- BOOT is entered on reset. Transitions to RUN on the first clock edge after rst deasserts; pc stays RESET_VEC.
- Next-PC priority, highest first:
  1. exc_req → EXC_VEC; also epc ← pc.
  2. eret → epc.
  3. br_taken → br_target.
  4. jmp_valid → jmp_target.
  5. ras_pop with ras not empty → RAS top; the entry is popped.
  6. stall → pc unchanged.
  7. Otherwise → pc + STEP, modulo 2^WIDTH; wraps silently.
- Redirects 1–5 override stall. Only the winning redirect has effect; a losing ras_pop does not pop. ras_pop on an empty RAS is ignored and falls through to 6/7.
- HALT behaviour:
  - RUN + halt (and no redirect) → HALT. pc holds.
  - In HALT, only exc_req is honoured. It redirects and returns to RUN. Other inputs are ignored; RAS pushes are also blocked.
  - HALT + resume → RUN, sequential advance resumes the following cycle.
- RAS is a circular buffer.
  - ras_push writes ras_push_addr as the new top and always occurs in RUN unless exc_req.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - Push and winning pop in the same cycle: redirect to the old top, and the top is replaced by ras_push_addr (count unchanged).
  - exc_req leaves the RAS untouched.

## Timing
- Reset values: pc=RESET_VEC, pc_valid=0, epc=0, flush=0, ras_empty=1, state BOOT.
- All outputs are registered. Every next-PC decision appears on pc one cycle after the inputs are sampled.
- pc_valid is 1 in RUN and 0 in BOOT and HALT. It is also 1 in the cycle the design enters RUN from HALT via exc_req.
- flush=1 for exactly one cycle, coincident with the redirected pc. It is 0 for sequential, stall and halt cycles.
- Reset mid-operation returns to BOOT immediately (asynchronously) and clears the RAS and epc.

## Structure
- Shared package mips_pc_pkg: state enum (BOOT/RUN/HALT), redirect-source enum for the priority mux, default vector constants (RESET_VEC, EXC_VEC).
- One sub-module, ras_stack: parametrised circular LIFO with push/pop/top/empty/count and overwrite-on-full. pc_gen holds the FSM, priority mux, pc/epc registers and flush register.

## Test plan
- Reset release, no other inputs → cycle 1: pc=0, pc_valid=0. Cycle 2: pc=0, pc_valid=1. Then 4, 8, 12.
- pc=0x10 with stall=1 and br_taken=1, br_target=0x200 → next pc=0x200, flush=1 for one cycle. A following stall-only cycle holds 0x200 with flush=0.
- exc_req at pc=0x44 with br_taken=1 simultaneously → pc=0x80000180, epc=0x44. A later eret → pc=0x44, flush=1.
- RAS_DEPTH=4: push 0x100, 0x104, 0x108, 0x10C, 0x110; five pops → redirects to 0x110, 0x10C, 0x108, 0x104. Then ras_empty=1, and the fifth pop falls through to sequential.
- halt at pc=0x20 → pc holds 0x20 with pc_valid=0; br_taken is ignored. exc_req → pc=EXC_VEC, pc_valid=1, state RUN.
- WIDTH=8, STEP=4, pc=0xFC, no inputs → next pc=0x00.
